video_timing_gen: RTL
=====================

// Module: video_timing_gen
// PURPOSE
// - Raster timing generator in the DVI pixel-clock domain, fed by the video clock and lock flag from pll_main.
// - Produces the registered hsync/vsync/de/x/y stream that drives the DVI transmitter.
// - Produces frame_start and frame_counter, which lag-measurement logic uses to timestamp each frame.
// - Holds the raster idle until the PLL is locked and has settled.
// PARAMETERS
// - H_ACTIVE 640: active pixels per line.
// - H_FP 16: horizontal front porch, in pixels.
// - H_SYNC 96: hsync width, in pixels.
// - H_BP 48: horizontal back porch, in pixels.
// - V_ACTIVE 480: active lines per frame.
// - V_FP 10: vertical front porch, in lines.
// - V_SYNC 2: vsync width, in lines.
// - V_BP 33: vertical back porch, in lines.
// - H_SYNC_POL 0: hsync active level (1 = positive).
// - V_SYNC_POL 0: vsync active level (1 = positive).
// - SETTLE_CYCLES 1024: clocks to wait after locked rises; must be >=1.
// PORTS
// - clock  in  1  pixel clock (DVI_CLOCK); the only clock.
// - reset_n  in  1  synchronous reset, active-low.
// - locked  in  1  PLL lock flag; treated as asynchronous, double-flopped internally.
// - enable  in  1  raster run request.
// - hsync  out  1  horizontal sync.
// - vsync  out  1  vertical sync.
// - de  out  1  data enable (active video).
// - x  out  12  active pixel column; valid while de=1.
// - y  out  12  active line; valid while de=1.
// - frame_start  out  1  one-cycle pulse on the cycle the outputs show x=0,y=0.
// - frame_counter  out  16  count of completed frame_start pulses; wraps.
// - rgb  out  24  test pattern; tied to 0 when VTG_TEST_PATTERN_EN is undefined.
// BEHAVIOUR
// - Reset values: hsync=!H_SYNC_POL, vsync=!V_SYNC_POL, de=0, x=0, y=0, frame_start=0, frame_counter=0, rgb=0.
// - Reset puts the FSM in IDLE with h=v=0.
// - Counters: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP.
// - h counts 0..H_TOTAL-1. When h wraps, v increments; v wraps 0..V_TOTAL-1.
// - Decode from (h,v), all outputs registered (1-cycle latency from counters):
//   - de = h<H_ACTIVE && v<V_ACTIVE.
//   - hsync active when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
//   - vsync active when V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC; vsync changes at h=0.
//   - x=h, y=v while de. x and y hold their last value while de=0.
// - FSM states IDLE, SETTLE, RUN:
//   - IDLE: counters held at 0, outputs at inactive levels. Go to SETTLE when locked_sync && enable.
//   - SETTLE: count SETTLE_CYCLES. Go to RUN at terminal count. On locked_sync=0 or enable=0, return to IDLE.
//   - RUN: counters advance. On locked_sync=0, go to IDLE next cycle and force outputs inactive immediately (frame aborted, frame_counter unchanged).
//   - RUN: on enable=0, finish the current frame; go to IDLE when h=H_TOTAL-1 and v=V_TOTAL-1.
//   - RUN: if enable returns to 1 before frame end, continue without a gap.
// - The first RUN cycle has h=v=0, so frame_start pulses 1 cycle after RUN is entered.
// - frame_counter increments on each frame_start pulse; 0xFFFF wraps to 0x0000.
// - reset_n=0 mid-frame: all state returns to the reset values on the next edge.
// CONFIGURATION
// - With VTG_TEST_PATTERN_EN defined:
//   - rgb shows 8 vertical colour bars, each H_ACTIVE/8 wide: white, yellow, cyan, green, magenta, red, blue, black.
//   - Bar index = x[...]*8/H_ACTIVE, computed combinationally from h, registered with de (same latency).
//   - rgb=0 whenever de=0.
// - Without VTG_TEST_PATTERN_EN: rgb is constant 0 and no bar logic is synthesised.
// STRUCTURE
// - Package video_timing_pkg holds the vtg_state_t enum {IDLE, SETTLE, RUN}.
// - video_timing_pkg also holds the 12-bit coordinate width and 16-bit frame-counter width constants.
// - video_timing_pkg also holds the colour-bar RGB constants.
// - One sub-module, sync_2ff, synchronises locked into clock.
// - Counters, decode and FSM stay in this module.
// TESTING (sim params: H_ACTIVE=8, H_FP=2, H_SYNC=2, H_BP=2, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1, SETTLE_CYCLES=4)
// - Reset with locked=1, enable=1:
//   - all outputs hold their reset values while reset_n=0.
//   - first frame_start comes exactly 2(sync)+1+4+1 cycles after reset_n rises.
// - Steady run: check per line/frame timing.
//   - de high 8 of 14 clocks per line, on 4 of 7 lines.
//   - hsync low for h=10..11.
//   - vsync low for v=5 at h=0..13.
//   - frame_start period = 98 clocks.
// - locked drops mid-line in RUN:
//   - outputs go inactive within 3 cycles.
//   - frame_counter frozen.
//   - after relock: SETTLE of 4, then a fresh frame from x=0,y=0.
// - enable drops at v=1:
//   - current frame completes.
//   - no further frame_start.
//   - FSM reaches IDLE after v=6,h=13.
// - Start with frame_counter preloaded near wrap (force 0xFFFE):
//   - two frames later it reads 0x0000.
// - VTG_TEST_PATTERN_EN defined:
//   - x=0 -> rgb=FFFFFF; x=7 -> rgb=000000; de=0 -> rgb=0.

Source files
------------

// File: rtl/video_timing_pkg.sv
// Shared types and constants for the raster timing generator:
// FSM state encoding, coordinate/counter widths and colour-bar palette.
package video_timing_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2
  } vtg_state_t;

  localparam int COORD_W = 12;
  localparam int FRAME_W = 16;
  localparam int RGB_W   = 24;

  localparam logic [RGB_W-1:0] RGB_WHITE   = 24'hFFFFFF;
  localparam logic [RGB_W-1:0] RGB_YELLOW  = 24'hFFFF00;
  localparam logic [RGB_W-1:0] RGB_CYAN    = 24'h00FFFF;
  localparam logic [RGB_W-1:0] RGB_GREEN   = 24'h00FF00;
  localparam logic [RGB_W-1:0] RGB_MAGENTA = 24'hFF00FF;
  localparam logic [RGB_W-1:0] RGB_RED     = 24'hFF0000;
  localparam logic [RGB_W-1:0] RGB_BLUE    = 24'h0000FF;
  localparam logic [RGB_W-1:0] RGB_BLACK   = 24'h000000;

  // Bars run left to right in the classic SMPTE-like order.
  function automatic logic [RGB_W-1:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_colour = RGB_WHITE;
      3'd1:    bar_colour = RGB_YELLOW;
      3'd2:    bar_colour = RGB_CYAN;
      3'd3:    bar_colour = RGB_GREEN;
      3'd4:    bar_colour = RGB_MAGENTA;
      3'd5:    bar_colour = RGB_RED;
      3'd6:    bar_colour = RGB_BLUE;
      default: bar_colour = RGB_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser bringing the asynchronous PLL lock flag into the
// pixel-clock domain; output reads 0 out of reset.
module sync_2ff (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: IDLE/SETTLE/RUN FSM, h/v counters and registered
// sync/de/x/y decode. Colour bars on rgb are built only with VTG_TEST_PATTERN_EN.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE      = 640,
  parameter int H_FP          = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BP          = 48,
  parameter int V_ACTIVE      = 480,
  parameter int V_FP          = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BP          = 33,
  parameter int H_SYNC_POL    = 0,
  parameter int V_SYNC_POL    = 0,
  parameter int SETTLE_CYCLES = 1024
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               locked,
  input  logic               enable,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_counter,
  output logic [RGB_W-1:0]   rgb,
  output vtg_state_t         state_dbg
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);

  localparam logic [COORD_W-1:0] H_ACT_C   = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] H_SS_C    = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] H_SE_C    = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] H_LAST_C  = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_ACT_C   = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] V_SS_C    = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] V_SE_C    = COORD_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [COORD_W-1:0] V_LAST_C  = COORD_W'(V_TOTAL - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic HS_ON = (H_SYNC_POL != 0);
  localparam logic VS_ON = (V_SYNC_POL != 0);

  logic                locked_sync;
  vtg_state_t          state, state_next;
  logic [COORD_W-1:0]  h, v;
  logic [SETTLE_W-1:0] settle_cnt;
  logic                h_last, v_last, settle_done;
  logic                count_en, settle_en;
  logic                de_d, hs_act, vs_act;
  logic [RGB_W-1:0]    rgb_d;

  sync_2ff u_lock_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (locked),
    .q       (locked_sync)
  );

  assign h_last      = (h == H_LAST_C);
  assign v_last      = (v == V_LAST_C);
  assign settle_done = (settle_cnt == SETTLE_LAST);
  assign state_dbg   = state;

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (locked_sync && enable) state_next = SETTLE;
      SETTLE:  if (!locked_sync || !enable) state_next = IDLE;
               else if (settle_done)        state_next = RUN;
      RUN:     if (!locked_sync)                      state_next = IDLE;
               else if (!enable && h_last && v_last)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Counting stops the same cycle lock is lost, so outputs blank without waiting for the state change.
  always_comb begin
    count_en  = 1'b0;
    settle_en = 1'b0;
    case (state)
      SETTLE:  settle_en = 1'b1;
      RUN:     count_en  = locked_sync;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n || !settle_en) settle_cnt <= '0;
    else                        settle_cnt <= settle_cnt + SETTLE_W'(1);
  end

  always_ff @(posedge clock) begin
    if (!reset_n || !count_en) begin
      h <= '0;
      v <= '0;
    end else if (h_last) begin
      h <= '0;
      v <= v_last ? '0 : v + COORD_W'(1);
    end else begin
      h <= h + COORD_W'(1);
    end
  end

  assign de_d   = count_en && (h < H_ACT_C) && (v < V_ACT_C);
  assign hs_act = count_en && (h >= H_SS_C) && (h < H_SE_C);
  assign vs_act = count_en && (v >= V_SS_C) && (v < V_SE_C);

`ifdef VTG_TEST_PATTERN_EN
  logic [2:0] bar_idx;
  assign bar_idx = 3'((32'(h) * 32'd8) / 32'(H_ACTIVE));
  assign rgb_d   = de_d ? bar_colour(bar_idx) : '0;
`else
  assign rgb_d   = '0;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      hsync         <= ~HS_ON;
      vsync         <= ~VS_ON;
      de            <= 1'b0;
      x             <= '0;
      y             <= '0;
      frame_start   <= 1'b0;
      frame_counter <= '0;
      rgb           <= '0;
    end else begin
      hsync       <= hs_act ? HS_ON : ~HS_ON;
      vsync       <= vs_act ? VS_ON : ~VS_ON;
      de          <= de_d;
      frame_start <= count_en && (h == '0) && (v == '0);
      rgb         <= rgb_d;
      if (de_d) begin
        x <= h;
        y <= v;
      end
      if (frame_start) frame_counter <= frame_counter + FRAME_W'(1);
    end
  end

endmodule
